// File: rtl/load_store_mc.sv
// Multi-channel fill/drain level controller with per-channel enable,
// saturating step, programmable end dwell and registered full/empty flags.
module load_store_mc #(
    parameter int NCH   = 4,
    parameter int CBITS = 15,
    parameter int LIMIT = 17500,
    parameter int STEP  = 1,
    parameter int HOLD  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       en,
    output logic [NCH-1:0]       sig,
    output logic [NCH-1:0]       empty,
    output logic [NCH-1:0]       mode,
    output logic [NCH*CBITS-1:0] level
);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        HOLD_HI = 2'd1,
        DRAIN   = 2'd2,
        HOLD_LO = 2'd3
    } state_t;

    localparam logic [CBITS:0]   LIM_W  = (CBITS+1)'(LIMIT);
    localparam logic [CBITS:0]   STEP_W = (CBITS+1)'(STEP);
    localparam logic [CBITS-1:0] LIM_N  = CBITS'(LIMIT);
    localparam logic [CBITS-1:0] STEP_N = CBITS'(STEP);
    localparam logic [7:0]       HOLD_N = 8'(HOLD);
    localparam bit               DWELL  = (HOLD > 0);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t           st_q, st_d;
        logic [CBITS-1:0] lev_q, lev_d;
        logic [7:0]       cnt_q, cnt_d;
        logic [CBITS:0]   up;
        logic             sig_q, emp_q;

        // Sum is one bit wider than the level so the clamp never sees a wrap
        assign up = {1'b0, lev_q} + STEP_W;

        always_comb begin
            st_d  = st_q;
            lev_d = lev_q;
            cnt_d = cnt_q;
            if (en[i]) begin
                case (st_q)
                    FILL: begin
                        if (up >= LIM_W) begin
                            lev_d = LIM_N;
                            if (DWELL) begin
                                st_d  = HOLD_HI;
                                cnt_d = HOLD_N;
                            end else begin
                                st_d  = DRAIN;
                            end
                        end else begin
                            lev_d = up[CBITS-1:0];
                        end
                    end
                    HOLD_HI: begin
                        cnt_d = cnt_q - 8'd1;
                        if (cnt_q <= 8'd1) begin
                            cnt_d = 8'd0;
                            st_d  = DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (lev_q > STEP_N) begin
                            lev_d = lev_q - STEP_N;
                        end else begin
                            lev_d = '0;
                            if (DWELL) begin
                                st_d  = HOLD_LO;
                                cnt_d = HOLD_N;
                            end else begin
                                st_d  = FILL;
                            end
                        end
                    end
                    HOLD_LO: begin
                        cnt_d = cnt_q - 8'd1;
                        if (cnt_q <= 8'd1) begin
                            cnt_d = 8'd0;
                            st_d  = FILL;
                        end
                    end
                    default: begin
                        st_d  = FILL;
                        cnt_d = 8'd0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                st_q  <= FILL;
                lev_q <= '0;
                cnt_q <= 8'd0;
                sig_q <= 1'b0;
                emp_q <= 1'b1;
            end else begin
                st_q  <= st_d;
                lev_q <= lev_d;
                cnt_q <= cnt_d;
                sig_q <= (lev_d == LIM_N);
                emp_q <= (lev_d == '0);
            end
        end

        assign sig[i]                  = sig_q;
        assign empty[i]                = emp_q;
        assign mode[i]                 = (st_q == FILL);
        assign level[i*CBITS +: CBITS] = lev_q;
    end

endmodule
